sudoku_bt_solver: RTL and testbench
===================================

# sudoku_bt_solver

Parametrised backtracking Sudoku solver with on-chip grid storage, cursor-driven puzzle entry and solution display. Grid side is BOX*BOX, so one RTL source serves 4x4, 9x9 and 16x16 puzzles. Adds a step counter, an optional step-limit timeout and a post-solve reload path. It sits between the board's button/switch debouncers and the display/VGA driver, which reads the cell under the cursor.

## Interface
- BOX, 3: box edge. SIDE = BOX*BOX; legal BOX is 2..4.
- MAX_STEPS, 0: candidate-assignment limit. 0 means no limit.
- SW, 24: StepCount width.
- Derived: VW = $clog2(SIDE+1) value width; IW = $clog2(SIDE) index width.
- Clk  in  1  single clock, all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- Prev, Next, Enter, Start  in  1 each  single-cycle pulses from the debouncers.
- InputValue  in  VW  value to write; 0 clears the cell.
- Row, Col  out  IW each  cursor position, or the solver cell while solving.
- OutputValue  out  VW  grid value at (Row,Col).
- CellFixed  out  1  cell at (Row,Col) is a given.
- Busy  out  1  state is FORWARD, VALIDATE or BACK.
- Done  out  1  state is DISP.
- Fail  out  1  state is FAIL.
- Timeout  out  1  FAIL was entered because of MAX_STEPS.
- StepCount  out  SW  candidate assignments since Start; saturates at all-ones.

## Operation
- States: INIT, LOAD, FORWARD, VALIDATE, BACK, DISP, FAIL.
- Storage: SIDE*SIDE value registers of VW bits each, plus one fixed bit per cell. Linear index idx = Row*SIDE+Col.
- INIT: clears all values, all fixed bits, the cursor, StepCount and Timeout. Next state is LOAD.
- LOAD, cursor movement:
  - Next moves Col+1. From Col=SIDE-1 it goes to Col 0 of the next row. From (SIDE-1,SIDE-1) it wraps to (0,0).
  - Prev is the exact inverse.
  - Prev and Next in the same cycle: no move.
- LOAD, Enter:
  - InputValue 1..SIDE writes the cell and sets its fixed bit.
  - 0 writes 0 and clears the fixed bit.
  - Any value above SIDE is ignored.
  - Enter together with Next or Prev: the write goes to the old cursor, then the cursor moves.
- LOAD, Start: wins over Enter in the same cycle (Enter is dropped). It clears every non-fixed cell, StepCount and Timeout, sets idx=0 and goes to FORWARD.
- FORWARD at idx:
  - Fixed cell: if idx is last, go to DISP; else idx+1 and stay in FORWARD.
  - Otherwise compute cand = cell+1.
  - cand > SIDE: write cell to 0 and go to BACK.
  - Else: write cell=cand, StepCount+1, k=0, go to VALIDATE.
  - If MAX_STEPS != 0 and StepCount has reached MAX_STEPS before the increment, go to FAIL with Timeout=1 instead.
- VALIDATE, one k per cycle, k = 0..SIDE-1:
  - Compare cell[idx] against row cell (r,k), column cell (k,c) and the k-th cell of idx's box, row-major inside the box.
  - Positions equal to idx are excluded. Zero-valued cells never conflict.
  - Any conflict: go to FORWARD at the same idx, which tries the next candidate.
  - k=SIDE-1 with no conflict: if idx is last, go to DISP; else idx+1 and go to FORWARD.
- BACK:
  - idx=0: go to FAIL.
  - Else idx-1. Go to FORWARD if cell idx-1 is not fixed; otherwise stay in BACK.
- Candidate order is ascending, so the result is the lexicographically smallest solution.
- Givens are not cross-checked against each other. A conflict that exists only among givens is not detected.
- DISP / FAIL:
  - Grid is frozen; cursor navigation works as in LOAD.
  - Start is ignored.
  - Enter clears all non-fixed cells, keeps the givens and goes to LOAD.

## Timing
- Reset, and the cycle after it: all outputs 0 and state INIT. Cursor is (0,0). LOAD is entered on the following edge.
- Reset asserted in any state, including mid-solve, takes effect on the next edge. It overrides all other inputs.
- Start to the first FORWARD cycle: 1 cycle. Busy rises on the same edge.
- FORWARD costs 1 cycle. VALIDATE costs 1..SIDE cycles. BACK costs 1 cycle per cell stepped.
- Row/Col follow idx while Busy. On reaching DISP or FAIL the cursor holds the last idx.
- Done, Fail and Timeout are registered with the state and change together.
- Timeout stays set until Start or INIT.
- StepCount stays frozen in DISP and FAIL.
- OutputValue and CellFixed are combinational reads of the current grid at (Row,Col).

## Test plan
- Reset: Reset high for 2 cycles -> one INIT cycle, then LOAD. Row=Col=0, OutputValue=0, Done=Fail=Busy=0, StepCount=0.
- Cursor and entry, BOX=3:
  - Prev at (0,0) -> (8,8); Next at (8,8) -> (0,0); Next at (0,8) -> (1,0).
  - Enter with 10 -> cell unchanged. Enter with 5 -> OutputValue=5, CellFixed=1. Enter with 0 -> 0, CellFixed=0.
- Empty grid, BOX=2, Start -> Done. Rows read 1234 / 3412 / 2143 / 4321; Fail=0.
- Unsolvable, BOX=2: givens (0,0)=1, (0,1)=2, (0,2)=3, (1,3)=4, then Start -> Fail=1, Timeout=0. Givens remain visible.
- Timeout, BOX=3, MAX_STEPS=10: empty grid, Start -> Fail=1, Timeout=1, StepCount=10.
- Recovery:
  - Reset during Busy -> INIT then LOAD; grid all zero.
  - Separately: Enter in DISP -> LOAD with only the givens kept; a second Start reproduces the identical solution.

Source files
------------

// File: rtl/sudoku_bt_solver_if.sv
// Button/switch side and display side of the Sudoku solver, bundled as one bus.
// The master drives the debounced pulses and the entry value; the slave is the solver.
interface sudoku_bt_solver_if #(
   parameter int BOX = 3,
   parameter int SW  = 24
);
   localparam int SIDE = BOX * BOX;
   localparam int VW   = $clog2(SIDE + 1);
   localparam int IW   = $clog2(SIDE);

   logic          prev;
   logic          next;
   logic          enter;
   logic          start;
   logic [VW-1:0] input_value;
   logic [IW-1:0] row;
   logic [IW-1:0] col;
   logic [VW-1:0] output_value;
   logic          cell_fixed;
   logic          busy;
   logic          done;
   logic          fail;
   logic          timeout;
   logic [SW-1:0] step_count;

   modport master (
      output prev, next, enter, start, input_value,
      input  row, col, output_value, cell_fixed, busy, done, fail, timeout, step_count
   );

   modport slave (
      input  prev, next, enter, start, input_value,
      output row, col, output_value, cell_fixed, busy, done, fail, timeout, step_count
   );
endinterface

// File: rtl/sudoku_bt_solver.sv
// Backtracking Sudoku solver for a BOX*BOX grid: cursor-driven entry, row-major
// depth-first search with ascending candidates, and cursor-driven result display.
module sudoku_bt_solver #(
   parameter int BOX       = 3,
   parameter int MAX_STEPS = 0,
   parameter int SW        = 24
) (
   input logic             clk,
   input logic             reset,
   sudoku_bt_solver_if.slave bus
);
   localparam int SIDE  = BOX * BOX;
   localparam int VW    = $clog2(SIDE + 1);
   localparam int IW    = $clog2(SIDE);
   localparam int CELLS = SIDE * SIDE;
   localparam int AW    = $clog2(CELLS);
   localparam logic [IW-1:0] LAST  = IW'(SIDE - 1);
   localparam logic [VW:0]   LIMIT = (VW + 1)'(SIDE);

   typedef enum logic [2:0] {INIT, LOAD, FORWARD, VALIDATE, BACK, DISP, FAIL} state_t;

   state_t        state;
   state_t        state_next;
   logic [VW-1:0] grid [CELLS];
   logic [CELLS-1:0] fixed;
   logic [IW-1:0] cur_row;
   logic [IW-1:0] cur_col;
   logic [IW-1:0] k;
   logic [SW-1:0] step_cnt;
   logic          timeout_r;

   logic [IW-1:0] fwd_row, fwd_col, bwd_row, bwd_col;
   logic [IW-1:0] box_row, box_col;
   logic [AW-1:0] cur_addr, bwd_addr;
   logic [VW-1:0] cur_val, row_val, col_val, box_val;
   logic [VW:0]   cand;
   logic          cur_fix, is_last, is_first, conflict, limit_hit, input_ok;

   function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] r, input logic [IW-1:0] c);
      return AW'(r) * AW'(SIDE) + AW'(c);
   endfunction

   // The solver walks the grid with the cursor itself, so idx+1 / idx-1 are
   // the same row-major wrap moves used by Next / Prev.
   always_comb begin
      fwd_row = cur_row;
      fwd_col = cur_col + 1'b1;
      if (cur_col == LAST) begin
         fwd_col = '0;
         fwd_row = (cur_row == LAST) ? '0 : cur_row + 1'b1;
      end
      bwd_row = cur_row;
      bwd_col = cur_col - 1'b1;
      if (cur_col == '0) begin
         bwd_col = LAST;
         bwd_row = (cur_row == '0) ? LAST : cur_row - 1'b1;
      end
   end

   assign cur_addr  = addr_of(cur_row, cur_col);
   assign bwd_addr  = addr_of(bwd_row, bwd_col);
   assign cur_val   = grid[cur_addr];
   assign cur_fix   = fixed[cur_addr];
   assign is_last   = (cur_row == LAST) && (cur_col == LAST);
   assign is_first  = (cur_row == '0) && (cur_col == '0);
   assign cand      = {1'b0, cur_val} + 1'b1;
   assign limit_hit = (MAX_STEPS != 0) && (step_cnt >= SW'(MAX_STEPS));
   assign input_ok  = ({1'b0, bus.input_value} <= LIMIT);

   // Peer k of the current cell in its row, column and box; a peer that is the
   // cell itself or holds zero never conflicts.
   assign box_row = IW'((int'(cur_row) / BOX) * BOX + int'(k) / BOX);
   assign box_col = IW'((int'(cur_col) / BOX) * BOX + int'(k) % BOX);
   assign row_val = grid[addr_of(cur_row, k)];
   assign col_val = grid[addr_of(k, cur_col)];
   assign box_val = grid[addr_of(box_row, box_col)];

   always_comb begin
      conflict = 1'b0;
      if ((k != cur_col) && (row_val != '0) && (row_val == cur_val)) conflict = 1'b1;
      if ((k != cur_row) && (col_val != '0) && (col_val == cur_val)) conflict = 1'b1;
      if (!((box_row == cur_row) && (box_col == cur_col)) && (box_val != '0) &&
          (box_val == cur_val)) conflict = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:     state_next = LOAD;
         LOAD:     if (bus.start) state_next = FORWARD;
         FORWARD: begin
            if (cur_fix) begin
               if (is_last) state_next = DISP;
            end else if (cand > LIMIT) begin
               state_next = BACK;
            end else if (limit_hit) begin
               state_next = FAIL;
            end else begin
               state_next = VALIDATE;
            end
         end
         VALIDATE: begin
            if (conflict)         state_next = FORWARD;
            else if (k == LAST)   state_next = is_last ? DISP : FORWARD;
         end
         BACK: begin
            if (is_first)               state_next = FAIL;
            else if (!fixed[bwd_addr])  state_next = FORWARD;
         end
         DISP, FAIL: if (bus.enter) state_next = LOAD;
         default:  state_next = INIT;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      bus.fail = 1'b0;
      case (state)
         FORWARD, VALIDATE, BACK: bus.busy = 1'b1;
         DISP:                    bus.done = 1'b1;
         FAIL:                    bus.fail = 1'b1;
         default:                 ;
      endcase
   end

   assign bus.row          = cur_row;
   assign bus.col          = cur_col;
   assign bus.output_value = cur_val;
   assign bus.cell_fixed   = cur_fix;
   assign bus.timeout      = timeout_r;
   assign bus.step_count   = step_cnt;

   always_ff @(posedge clk) begin
      if (reset || (state == INIT)) begin
         for (int i = 0; i < CELLS; i++) grid[AW'(i)] <= '0;
         fixed     <= '0;
         cur_row   <= '0;
         cur_col   <= '0;
         k         <= '0;
         step_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (bus.start) begin
                  for (int i = 0; i < CELLS; i++)
                     if (!fixed[AW'(i)]) grid[AW'(i)] <= '0;
                  cur_row   <= '0;
                  cur_col   <= '0;
                  step_cnt  <= '0;
                  timeout_r <= 1'b0;
               end else begin
                  if (bus.enter && input_ok) begin
                     grid[cur_addr]  <= bus.input_value;
                     fixed[cur_addr] <= (bus.input_value != '0);
                  end
                  if (bus.next && !bus.prev) begin
                     cur_row <= fwd_row;
                     cur_col <= fwd_col;
                  end else if (bus.prev && !bus.next) begin
                     cur_row <= bwd_row;
                     cur_col <= bwd_col;
                  end
               end
            end
            FORWARD: begin
               if (cur_fix) begin
                  if (!is_last) begin
                     cur_row <= fwd_row;
                     cur_col <= fwd_col;
                  end
               end else if (cand > LIMIT) begin
                  grid[cur_addr] <= '0;
               end else if (limit_hit) begin
                  timeout_r <= 1'b1;
               end else begin
                  grid[cur_addr] <= cand[VW-1:0];
                  if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
                  k <= '0;
               end
            end
            VALIDATE: begin
               if (!conflict) begin
                  if (k == LAST) begin
                     if (!is_last) begin
                        cur_row <= fwd_row;
                        cur_col <= fwd_col;
                     end
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            BACK: begin
               if (!is_first) begin
                  cur_row <= bwd_row;
                  cur_col <= bwd_col;
               end
            end
            DISP, FAIL: begin
               if (bus.enter) begin
                  for (int i = 0; i < CELLS; i++)
                     if (!fixed[AW'(i)]) grid[AW'(i)] <= '0;
               end
               if (bus.next && !bus.prev) begin
                  cur_row <= fwd_row;
                  cur_col <= fwd_col;
               end else if (bus.prev && !bus.next) begin
                  cur_row <= bwd_row;
                  cur_col <= bwd_col;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sudoku_bt_solver.sv
// Bench for sudoku_bt_solver: a 4x4 instance for solving and recovery, a 9x9
// instance with a 10-step limit for cursor, entry and timeout behaviour.
module tb_sudoku_bt_solver;
   logic clk = 1'b0;
   logic reset2 = 1'b0;
   logic reset3 = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   expq[$];
   int   sol[16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};

   always #5 clk = ~clk;

   sudoku_bt_solver_if #(.BOX(2), .SW(24)) if2 ();
   sudoku_bt_solver_if #(.BOX(3), .SW(24)) if3 ();

   sudoku_bt_solver #(.BOX(2), .MAX_STEPS(0), .SW(24)) dut2 (.clk(clk), .reset(reset2), .bus(if2));
   sudoku_bt_solver #(.BOX(3), .MAX_STEPS(10), .SW(24)) dut3 (.clk(clk), .reset(reset3), .bus(if3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press2(input bit p, input bit n, input bit e, input bit s, input int v);
      if2.prev = p; if2.next = n; if2.enter = e; if2.start = s; if2.input_value = 3'(v);
      tick();
      if2.prev = 1'b0; if2.next = 1'b0; if2.enter = 1'b0; if2.start = 1'b0; if2.input_value = '0;
   endtask

   task automatic press3(input bit p, input bit n, input bit e, input bit s, input int v);
      if3.prev = p; if3.next = n; if3.enter = e; if3.start = s; if3.input_value = 4'(v);
      tick();
      if3.prev = 1'b0; if3.next = 1'b0; if3.enter = 1'b0; if3.start = 1'b0; if3.input_value = '0;
   endtask

   task automatic goto2(input int r, input int c);
      bit hit = 1'b0;
      for (int i = 0; i <= 16 && !hit; i++) begin
         if (if2.row == 2'(r) && if2.col == 2'(c)) hit = 1'b1;
         else press2(0, 1, 0, 0, 0);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("[TB] FAIL goto2 target (%0d,%0d): cursor at (%0d,%0d)", r, c, if2.row, if2.col);
      end
   endtask

   task automatic goto3(input int r, input int c);
      bit hit = 1'b0;
      for (int i = 0; i <= 81 && !hit; i++) begin
         if (if3.row == 4'(r) && if3.col == 4'(c)) hit = 1'b1;
         else press3(0, 1, 0, 0, 0);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("[TB] FAIL goto3 target (%0d,%0d): cursor at (%0d,%0d)", r, c, if3.row, if3.col);
      end
   endtask

   task automatic enter2(input int r, input int c, input int v);
      goto2(r, c);
      press2(0, 0, 1, 0, v);
   endtask

   // Walks the 4x4 grid row-major and compares each cell with the next queued value.
   task automatic readout2(input string name);
      goto2(0, 0);
      for (int i = 0; i < 16; i++) begin
         int e;
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s cell %0d: got %0d, no expected value queued", name, i, if2.output_value);
         end else begin
            e = expq.pop_front();
            if (if2.output_value !== 3'(e)) begin
               errors++;
               $display("[TB] FAIL %s cell %0d: got %0d, expected %0d", name, i, if2.output_value, e);
            end
         end
         press2(0, 1, 0, 0, 0);
      end
   endtask

   task automatic wait_end2(input string name, input int budget);
      int n = 0;
      while (!(if2.done || if2.fail) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!(if2.done || if2.fail)) begin
         errors++;
         $display("[TB] FAIL %s: no done/fail after %0d cycles, busy=%0b", name, budget, if2.busy);
      end
   endtask

   task automatic wait_end3(input string name, input int budget);
      int n = 0;
      while (!(if3.done || if3.fail) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!(if3.done || if3.fail)) begin
         errors++;
         $display("[TB] FAIL %s: no done/fail after %0d cycles, busy=%0b", name, budget, if3.busy);
      end
   endtask

   task automatic push_solution();
      for (int i = 0; i < 16; i++) expq.push_back(sol[i]);
   endtask

   task automatic test_reset();
      reset2 = 1'b1; reset3 = 1'b1;
      tick(); tick();
      reset2 = 1'b0; reset3 = 1'b0;
      checks++;
      if ({if3.busy, if3.done, if3.fail, if3.timeout} !== 4'b0 || if3.row !== 4'd0 ||
          if3.col !== 4'd0 || if3.output_value !== 4'd0 || if3.step_count !== 24'd0) begin
         errors++;
         $display("[TB] FAIL reset outputs: b/d/f/t=%0b%0b%0b%0b rc=(%0d,%0d) val=%0d steps=%0d, expected all 0",
                  if3.busy, if3.done, if3.fail, if3.timeout, if3.row, if3.col, if3.output_value, if3.step_count);
      end
      checks++;
      if ({if2.busy, if2.done, if2.fail, if2.row, if2.col, if2.output_value} !== '0) begin
         errors++;
         $display("[TB] FAIL reset outputs 4x4: b/d/f=%0b%0b%0b rc=(%0d,%0d) val=%0d, expected all 0",
                  if2.busy, if2.done, if2.fail, if2.row, if2.col, if2.output_value);
      end
      // This edge is the single INIT cycle, so Next must be ignored.
      press3(0, 1, 0, 0, 0);
      checks++;
      if (if3.col !== 4'd0 || if3.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL init cycle ignores next: col=%0d busy=%0b, expected col 0 busy 0", if3.col, if3.busy);
      end
      press3(0, 1, 0, 0, 0);
      checks++;
      if (if3.col !== 4'd1) begin
         errors++;
         $display("[TB] FAIL load next after init: col=%0d, expected 1", if3.col);
      end
      press3(1, 0, 0, 0, 0);
   endtask

   task automatic test_cursor();
      press3(1, 0, 0, 0, 0);
      checks++;
      if (if3.row !== 4'd8 || if3.col !== 4'd8) begin
         errors++;
         $display("[TB] FAIL prev wrap: (%0d,%0d), expected (8,8)", if3.row, if3.col);
      end
      press3(0, 1, 0, 0, 0);
      checks++;
      if (if3.row !== 4'd0 || if3.col !== 4'd0) begin
         errors++;
         $display("[TB] FAIL next wrap: (%0d,%0d), expected (0,0)", if3.row, if3.col);
      end
      goto3(0, 8);
      press3(0, 1, 0, 0, 0);
      checks++;
      if (if3.row !== 4'd1 || if3.col !== 4'd0) begin
         errors++;
         $display("[TB] FAIL next row carry: (%0d,%0d), expected (1,0)", if3.row, if3.col);
      end
      press3(1, 1, 0, 0, 0);
      checks++;
      if (if3.row !== 4'd1 || if3.col !== 4'd0) begin
         errors++;
         $display("[TB] FAIL prev+next hold: (%0d,%0d), expected (1,0)", if3.row, if3.col);
      end
   endtask

   task automatic test_entry();
      press3(0, 0, 1, 0, 10);
      checks++;
      if (if3.output_value !== 4'd0 || if3.cell_fixed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL enter 10 on empty: val=%0d fixed=%0b, expected 0/0", if3.output_value, if3.cell_fixed);
      end
      press3(0, 0, 1, 0, 5);
      checks++;
      if (if3.output_value !== 4'd5 || if3.cell_fixed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL enter 5: val=%0d fixed=%0b, expected 5/1", if3.output_value, if3.cell_fixed);
      end
      press3(0, 0, 1, 0, 10);
      checks++;
      if (if3.output_value !== 4'd5 || if3.cell_fixed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL enter 10 keeps 5: val=%0d fixed=%0b, expected 5/1", if3.output_value, if3.cell_fixed);
      end
      press3(0, 0, 1, 0, 0);
      checks++;
      if (if3.output_value !== 4'd0 || if3.cell_fixed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL enter 0: val=%0d fixed=%0b, expected 0/0", if3.output_value, if3.cell_fixed);
      end
      press3(0, 1, 1, 0, 7);
      checks++;
      if (if3.row !== 4'd1 || if3.col !== 4'd1 || if3.output_value !== 4'd0) begin
         errors++;
         $display("[TB] FAIL enter+next new cell: (%0d,%0d) val=%0d, expected (1,1) val 0",
                  if3.row, if3.col, if3.output_value);
      end
      press3(1, 0, 0, 0, 0);
      checks++;
      if (if3.output_value !== 4'd7 || if3.cell_fixed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL enter+next old cell: val=%0d fixed=%0b, expected 7/1", if3.output_value, if3.cell_fixed);
      end
      press3(0, 0, 1, 0, 0);
   endtask

   task automatic test_timeout();
      press3(0, 0, 0, 1, 0);
      checks++;
      if (if3.busy !== 1'b1 || if3.row !== 4'd0 || if3.col !== 4'd0) begin
         errors++;
         $display("[TB] FAIL start 9x9: busy=%0b (%0d,%0d), expected busy at (0,0)", if3.busy, if3.row, if3.col);
      end
      wait_end3("timeout run", 2000);
      checks++;
      if (if3.fail !== 1'b1 || if3.timeout !== 1'b1 || if3.done !== 1'b0 || if3.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout flags: f/t/d/b=%0b%0b%0b%0b, expected 1100", if3.fail, if3.timeout, if3.done, if3.busy);
      end
      checks++;
      if (if3.step_count !== 24'd10 || if3.row !== 4'd0 || if3.col !== 4'd4) begin
         errors++;
         $display("[TB] FAIL timeout steps/cursor: steps=%0d (%0d,%0d), expected 10 at (0,4)",
                  if3.step_count, if3.row, if3.col);
      end
      press3(0, 0, 1, 0, 0);
      checks++;
      if (if3.fail !== 1'b0 || if3.timeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout held into load: fail=%0b timeout=%0b, expected 0/1", if3.fail, if3.timeout);
      end
      press3(0, 0, 0, 1, 0);
      checks++;
      if (if3.timeout !== 1'b0 || if3.step_count !== 24'd0) begin
         errors++;
         $display("[TB] FAIL start clears timeout: timeout=%0b steps=%0d, expected 0/0", if3.timeout, if3.step_count);
      end
   endtask

   task automatic test_solve_empty();
      push_solution();
      press2(0, 0, 0, 1, 0);
      checks++;
      if (if2.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy after start: %0b, expected 1", if2.busy);
      end
      wait_end2("empty solve", 3000);
      checks++;
      if (if2.done !== 1'b1 || if2.fail !== 1'b0 || if2.row !== 2'd3 || if2.col !== 2'd3) begin
         errors++;
         $display("[TB] FAIL empty solve end: done=%0b fail=%0b (%0d,%0d), expected 1/0 at (3,3)",
                  if2.done, if2.fail, if2.row, if2.col);
      end
      press2(0, 0, 0, 1, 0);
      checks++;
      if (if2.done !== 1'b1 || if2.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start in disp ignored: done=%0b busy=%0b, expected 1/0", if2.done, if2.busy);
      end
      readout2("empty solve");
   endtask

   task automatic test_unsolvable();
      press2(0, 0, 1, 0, 0);
      checks++;
      if (if2.done !== 1'b0 || if2.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL enter in disp: done=%0b busy=%0b, expected 0/0", if2.done, if2.busy);
      end
      enter2(0, 0, 1); enter2(0, 1, 2); enter2(0, 2, 3); enter2(1, 3, 4);
      for (int i = 0; i < 16; i++)
         expq.push_back(i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : i == 7 ? 4 : 0);
      press2(0, 0, 0, 1, 0);
      wait_end2("unsolvable", 3000);
      checks++;
      if (if2.fail !== 1'b1 || if2.timeout !== 1'b0 || if2.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unsolvable flags: fail=%0b timeout=%0b done=%0b, expected 1/0/0",
                  if2.fail, if2.timeout, if2.done);
      end
      checks++;
      if (if2.step_count !== 24'd4) begin
         errors++;
         $display("[TB] FAIL unsolvable steps: %0d, expected 4", if2.step_count);
      end
      readout2("unsolvable givens");
      goto2(0, 2);
      checks++;
      if (if2.cell_fixed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL given fixed bit: %0b, expected 1", if2.cell_fixed);
      end
   endtask

   task automatic test_reload();
      press2(0, 0, 1, 0, 0);
      enter2(0, 0, 0); enter2(0, 1, 0); enter2(0, 2, 0); enter2(1, 3, 0);
      enter2(0, 1, 2); enter2(2, 2, 4);
      push_solution();
      press2(0, 0, 0, 1, 0);
      wait_end2("givens solve", 3000);
      checks++;
      if (if2.done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL givens solve done: %0b, expected 1", if2.done);
      end
      readout2("givens solve");
      for (int i = 0; i < 16; i++) expq.push_back(i == 1 ? 2 : i == 10 ? 4 : 0);
      press2(0, 0, 1, 0, 0);
      checks++;
      if (if2.done !== 1'b0 || if2.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reload to load: done=%0b busy=%0b, expected 0/0", if2.done, if2.busy);
      end
      readout2("reload keeps givens");
      push_solution();
      press2(0, 0, 0, 1, 0);
      wait_end2("second solve", 3000);
      readout2("second solve");
   endtask

   task automatic test_reset_busy();
      press2(0, 0, 1, 0, 0);
      press2(0, 0, 0, 1, 0);
      tick(); tick();
      checks++;
      if (if2.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy before mid-solve reset: %0b, expected 1", if2.busy);
      end
      reset2 = 1'b1;
      tick();
      reset2 = 1'b0;
      checks++;
      if ({if2.busy, if2.done, if2.fail, if2.row, if2.col, if2.output_value} !== '0 ||
          if2.step_count !== 24'd0) begin
         errors++;
         $display("[TB] FAIL mid-solve reset: b/d/f=%0b%0b%0b rc=(%0d,%0d) val=%0d steps=%0d, expected all 0",
                  if2.busy, if2.done, if2.fail, if2.row, if2.col, if2.output_value, if2.step_count);
      end
      tick();
      for (int i = 0; i < 16; i++) expq.push_back(0);
      readout2("grid after reset");
   endtask

   initial begin
      if2.prev = 1'b0; if2.next = 1'b0; if2.enter = 1'b0; if2.start = 1'b0; if2.input_value = '0;
      if3.prev = 1'b0; if3.next = 1'b0; if3.enter = 1'b0; if3.start = 1'b0; if3.input_value = '0;
      test_reset();
      test_cursor();
      test_entry();
      test_timeout();
      test_solve_empty();
      test_unsolvable();
      test_reload();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
